// File: rtl/riscv_tpr_update_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : riscv_tpr_update_ctrl_if
// Description : Bundles the CSR write handshake and the ID/EX/WB pipeline
//               status/control signals that connect to the TPR update
//               controller.
//               slave  modport : controller side
//               master modport : CSR stage / pipeline side
// Ports       : csr_tpr_we_i, csr_tpr_wdata_i, csr_tpr_ready_o,
//               id_issue_i, wb_retire_i, flush_i, stall_id_o, tpr_o,
//               tpr_update_o, busy_o, err_o
// Revision    : 1.0 - initial release
// ============================================================================
interface riscv_tpr_update_ctrl_if;
  logic        csr_tpr_we_i;
  logic [31:0] csr_tpr_wdata_i;
  logic        csr_tpr_ready_o;
  logic        id_issue_i;
  logic        wb_retire_i;
  logic        flush_i;
  logic        stall_id_o;
  logic [31:0] tpr_o;
  logic        tpr_update_o;
  logic        busy_o;
  logic        err_o;

  modport slave (
    input  csr_tpr_we_i, csr_tpr_wdata_i, id_issue_i, wb_retire_i, flush_i,
    output csr_tpr_ready_o, stall_id_o, tpr_o, tpr_update_o, busy_o, err_o
  );

  modport master (
    output csr_tpr_we_i, csr_tpr_wdata_i, id_issue_i, wb_retire_i, flush_i,
    input  csr_tpr_ready_o, stall_id_o, tpr_o, tpr_update_o, busy_o, err_o
  );
endinterface
`default_nettype wire

// File: rtl/riscv_tpr_update_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : riscv_tpr_update_ctrl
// Description : Sequences Tag Propagation Register writes so a new tag-mode
//               policy takes effect exactly at an instruction boundary.
//               A CSR write stalls ID, waits until every instruction already
//               issued past ID has retired (or is flushed), commits the new
//               TPR value, then releases the stall.
// Ports       : clk  - core clock, rising edge
//               rst  - asynchronous active-high reset
//               bus  - slave side of riscv_tpr_update_ctrl_if
//                      (CSR write handshake, issue/retire/flush in,
//                       stall/TPR/update/busy/error out)
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_tpr_update_ctrl #(
  parameter int          MAX_INFLIGHT = 3,
  parameter logic [31:0] TPR_RESET    = 32'h0000_0000
) (
  input  wire logic                     clk,
  input  wire logic                     rst,
  riscv_tpr_update_ctrl_if.slave        bus
);

  localparam int            CW    = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CW-1:0] c_MAX = CW'(MAX_INFLIGHT);
  localparam logic [CW-1:0] c_ONE = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_inflight;
  logic [31:0]   r_pending;
  logic [31:0]   r_tpr;
  logic          r_update;
  logic          r_stall;
  logic          r_ready;
  logic          r_busy;
  logic          r_err;

  logic [CW-1:0] w_cnt_next;
  logic          w_cnt_err;
  logic          w_proto_err;

  // In-flight tracking. Flush wins over issue/retire; underflow and overflow
  // hold the counter and raise the sticky error instead of wrapping.
  always_comb begin
    w_cnt_next = r_inflight;
    w_cnt_err  = 1'b0;
    if (bus.flush_i) begin
      w_cnt_next = '0;
    end else if (bus.id_issue_i && !bus.wb_retire_i) begin
      if (r_inflight == c_MAX) begin
        w_cnt_err = 1'b1;
      end else begin
        w_cnt_next = r_inflight + c_ONE;
      end
    end else if (!bus.id_issue_i && bus.wb_retire_i) begin
      if (r_inflight == '0) begin
        w_cnt_err = 1'b1;
      end else begin
        w_cnt_next = r_inflight - c_ONE;
      end
    end
  end

  // ID must not issue while we hold it; it still gets counted above.
  assign w_proto_err = bus.id_issue_i && r_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inflight <= '0;
      r_err      <= 1'b0;
    end else begin
      r_inflight <= w_cnt_next;
      if (w_cnt_err || w_proto_err) begin
        r_err <= 1'b1;
      end
    end
  end

  // Control FSM. Every output is registered alongside the state so nothing
  // on the ID stall path depends combinationally on the inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_pending <= '0;
      r_tpr     <= TPR_RESET;
      r_update  <= 1'b0;
      r_stall   <= 1'b0;
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.csr_tpr_we_i && r_ready) begin
            r_pending <= bus.csr_tpr_wdata_i;
            r_state   <= ST_DRAIN;
            r_ready   <= 1'b0;
            r_stall   <= 1'b1;
            r_busy    <= 1'b1;
          end
        end
        ST_DRAIN: begin
          // Registered count is used: an instruction issued in the accept
          // cycle is already visible here and must drain under the old TPR.
          if ((r_inflight == '0) || bus.flush_i) begin
            r_tpr    <= r_pending;
            r_update <= 1'b1;
            r_state  <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          r_update <= 1'b0;
          r_state  <= ST_IDLE;
          r_ready  <= 1'b1;
          r_stall  <= 1'b0;
          r_busy   <= 1'b0;
        end
        default: begin
          r_update <= 1'b0;
          r_state  <= ST_IDLE;
          r_ready  <= 1'b1;
          r_stall  <= 1'b0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.csr_tpr_ready_o = r_ready;
  assign bus.stall_id_o      = r_stall;
  assign bus.tpr_o           = r_tpr;
  assign bus.tpr_update_o    = r_update;
  assign bus.busy_o          = r_busy;
  assign bus.err_o           = r_err;

endmodule
`default_nettype wire

// File: tb/tb_riscv_tpr_update_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscv_tpr_update_ctrl
// Description : Directed self-checking bench for riscv_tpr_update_ctrl.
//               Each step drives one cycle of inputs, queues the outputs
//               expected after the next rising edge, then pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_tpr_update_ctrl;

  localparam logic [31:0] c_TPR_RESET = 32'h0000_0000;

  logic clk;
  logic rst;

  riscv_tpr_update_ctrl_if bus ();

  riscv_tpr_update_ctrl #(
    .MAX_INFLIGHT (3),
    .TPR_RESET    (c_TPR_RESET)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        stall;
    logic        ready;
    logic        busy;
    logic [31:0] tpr;
    logic        upd;
    logic        err;
  } exp_t;

  exp_t q_exp[$];
  int   checks = 0;
  int   errors = 0;

  task automatic cmp(input string tag, input string fld,
                     input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s.%s observed %h expected %h", tag, fld, got, exp);
    end
  endtask

  task automatic push(input string tag, input logic stall, input logic ready,
                      input logic busy, input logic [31:0] tpr,
                      input logic upd, input logic err);
    exp_t e;
    e.tag = tag; e.stall = stall; e.ready = ready; e.busy = busy;
    e.tpr = tpr; e.upd = upd; e.err = err;
    q_exp.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    checks++;
    assert (q_exp.size() != 0) else begin
      errors++;
      $error("FAIL scoreboard observed empty queue expected entry");
    end
    if (q_exp.size() != 0) begin
      e = q_exp.pop_front();
      cmp(e.tag, "stall", {31'b0, bus.stall_id_o},      {31'b0, e.stall});
      cmp(e.tag, "ready", {31'b0, bus.csr_tpr_ready_o}, {31'b0, e.ready});
      cmp(e.tag, "busy",  {31'b0, bus.busy_o},          {31'b0, e.busy});
      cmp(e.tag, "tpr",   bus.tpr_o,                    e.tpr);
      cmp(e.tag, "upd",   {31'b0, bus.tpr_update_o},    {31'b0, e.upd});
      cmp(e.tag, "err",   {31'b0, bus.err_o},           {31'b0, e.err});
    end
  endtask

  // Expected-state shorthands: IDLE, DRAIN, COMMIT.
  task automatic exp_idle(input string tag, input logic [31:0] tpr, input logic err);
    push(tag, 1'b0, 1'b1, 1'b0, tpr, 1'b0, err);
  endtask
  task automatic exp_drain(input string tag, input logic [31:0] tpr, input logic err);
    push(tag, 1'b1, 1'b0, 1'b1, tpr, 1'b0, err);
  endtask
  task automatic exp_commit(input string tag, input logic [31:0] tpr, input logic err);
    push(tag, 1'b1, 1'b0, 1'b1, tpr, 1'b1, err);
  endtask

  // Drive one cycle of inputs, then check outputs just after the edge.
  task automatic step(input logic we, input logic [31:0] wd, input logic iss,
                      input logic ret, input logic fl);
    bus.csr_tpr_we_i    = we;
    bus.csr_tpr_wdata_i = wd;
    bus.id_issue_i      = iss;
    bus.wb_retire_i     = ret;
    bus.flush_i         = fl;
    @(posedge clk);
    #1;
    pop_check();
  endtask

  localparam logic [31:0] c_W1  = 32'hA5A5_0F0F;
  localparam logic [31:0] c_W2  = 32'h1111_2222;
  localparam logic [31:0] c_W3  = 32'h3333_4444;
  localparam logic [31:0] c_W4  = 32'h5555_6666;
  localparam logic [31:0] c_W5A = 32'hDEAD_0001;
  localparam logic [31:0] c_W5B = 32'hBEEF_0002;
  localparam logic [31:0] c_W6  = 32'h1234_5678;

  initial begin
    rst                 = 1'b1;
    bus.csr_tpr_we_i    = 1'b0;
    bus.csr_tpr_wdata_i = '0;
    bus.id_issue_i      = 1'b0;
    bus.wb_retire_i     = 1'b0;
    bus.flush_i         = 1'b0;

    // 1. Reset values, then a write into an empty pipeline.
    #3;
    exp_idle("reset", c_TPR_RESET, 1'b0);
    pop_check();
    @(posedge clk);
    #1;
    rst = 1'b0;

    exp_drain ("t1_T1", c_TPR_RESET, 1'b0); step(1'b1, c_W1, 1'b0, 1'b0, 1'b0);
    exp_commit("t1_T2", c_W1,        1'b0); step(1'b0, '0,   1'b0, 1'b0, 1'b0);
    exp_idle  ("t1_T3", c_W1,        1'b0); step(1'b0, '0,   1'b0, 1'b0, 1'b0);

    // 2. Two in flight; the write waits for both retires.
    exp_idle  ("t2_iss0", c_W1, 1'b0); step(1'b0, '0,   1'b1, 1'b0, 1'b0);
    exp_idle  ("t2_iss1", c_W1, 1'b0); step(1'b0, '0,   1'b1, 1'b0, 1'b0);
    exp_drain ("t2_T1",   c_W1, 1'b0); step(1'b1, c_W2, 1'b0, 1'b0, 1'b0);
    exp_drain ("t2_T2",   c_W1, 1'b0); step(1'b0, '0,   1'b0, 1'b0, 1'b0);
    exp_drain ("t2_T3",   c_W1, 1'b0); step(1'b0, '0,   1'b0, 1'b1, 1'b0);
    exp_drain ("t2_T4",   c_W1, 1'b0); step(1'b0, '0,   1'b0, 1'b0, 1'b0);
    exp_drain ("t2_T5",   c_W1, 1'b0); step(1'b0, '0,   1'b0, 1'b1, 1'b0);
    exp_commit("t2_T6",   c_W2, 1'b0); step(1'b0, '0,   1'b0, 1'b0, 1'b0);
    exp_idle  ("t2_T7",   c_W2, 1'b0); step(1'b0, '0,   1'b0, 1'b0, 1'b0);

    // 3. Two in flight, flush during DRAIN commits without retires.
    exp_idle  ("t3_iss0", c_W2, 1'b0); step(1'b0, '0,   1'b1, 1'b0, 1'b0);
    exp_idle  ("t3_iss1", c_W2, 1'b0); step(1'b0, '0,   1'b1, 1'b0, 1'b0);
    exp_drain ("t3_T1",   c_W2, 1'b0); step(1'b1, c_W3, 1'b0, 1'b0, 1'b0);
    exp_drain ("t3_T2",   c_W2, 1'b0); step(1'b0, '0,   1'b0, 1'b0, 1'b0);
    exp_commit("t3_T3",   c_W3, 1'b0); step(1'b0, '0,   1'b0, 1'b0, 1'b1);
    exp_idle  ("t3_T4",   c_W3, 1'b0); step(1'b0, '0,   1'b0, 1'b0, 1'b0);

    // 4. Simultaneous issue/retire holds the count at 1; one retire drains.
    exp_idle("t4_iss", c_W3, 1'b0); step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      exp_idle("t4_both", c_W3, 1'b0); step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    end
    exp_drain ("t4_T1", c_W3, 1'b0); step(1'b1, c_W4, 1'b0, 1'b0, 1'b0);
    exp_drain ("t4_T2", c_W3, 1'b0); step(1'b0, '0,   1'b0, 1'b1, 1'b0);
    exp_commit("t4_T3", c_W4, 1'b0); step(1'b0, '0,   1'b0, 1'b0, 1'b0);
    exp_idle  ("t4_T4", c_W4, 1'b0); step(1'b0, '0,   1'b0, 1'b0, 1'b0);

    // 5. Back-to-back: second write held until the first IDLE cycle.
    exp_drain ("t5_T1", c_W4,  1'b0); step(1'b1, c_W5A, 1'b0, 1'b0, 1'b0);
    exp_commit("t5_T2", c_W5A, 1'b0); step(1'b1, c_W5B, 1'b0, 1'b0, 1'b0);
    exp_idle  ("t5_T3", c_W5A, 1'b0); step(1'b1, c_W5B, 1'b0, 1'b0, 1'b0);
    exp_drain ("t5_T4", c_W5A, 1'b0); step(1'b1, c_W5B, 1'b0, 1'b0, 1'b0);
    exp_commit("t5_T5", c_W5B, 1'b0); step(1'b0, '0,    1'b0, 1'b0, 1'b0);
    exp_idle  ("t5_T6", c_W5B, 1'b0); step(1'b0, '0,    1'b0, 1'b0, 1'b0);

    // 6a. Issue while stalled flags an error; reset mid-DRAIN discards the write.
    exp_idle ("t6_iss",   c_W5B, 1'b0); step(1'b0, '0,   1'b1, 1'b0, 1'b0);
    exp_drain("t6_T1",    c_W5B, 1'b0); step(1'b1, c_W6, 1'b0, 1'b0, 1'b0);
    exp_drain("t6_viol",  c_W5B, 1'b1); step(1'b0, '0,   1'b1, 1'b0, 1'b0);
    bus.id_issue_i = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    exp_idle("t6_rst", c_TPR_RESET, 1'b0);
    pop_check();
    rst = 1'b0;
    exp_idle("t6_lost0", c_TPR_RESET, 1'b0); step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    exp_idle("t6_lost1", c_TPR_RESET, 1'b0); step(1'b0, '0, 1'b0, 1'b0, 1'b0);

    // 6b. Retire with nothing in flight sets a sticky error.
    exp_idle  ("t6_under", c_TPR_RESET, 1'b1); step(1'b0, '0,   1'b0, 1'b1, 1'b0);
    exp_idle  ("t6_stky0", c_TPR_RESET, 1'b1); step(1'b0, '0,   1'b0, 1'b0, 1'b0);
    exp_drain ("t6_stky1", c_TPR_RESET, 1'b1); step(1'b1, c_W1, 1'b0, 1'b0, 1'b0);
    exp_commit("t6_stky2", c_W1,        1'b1); step(1'b0, '0,   1'b0, 1'b0, 1'b0);
    exp_idle  ("t6_stky3", c_W1,        1'b1); step(1'b0, '0,   1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
